// File: rtl/ntt_addr_gen_if.sv
// Bundle between the poly controller, coefficient RAM / twiddle ROM and the butterfly.
// The address generator sits on the slave side; the controller and test drivers use master.
interface ntt_addr_gen_if;
    logic       start;
    logic       mode;
    logic       en;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_idx;
    logic [1:0] sel;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic [2:0] layer;
    logic       busy;
    logic       done;

    modport master (
        output start, mode, en,
        input  rd_en, rd_addr_a, rd_addr_b, tw_idx, sel,
        input  wr_en, wr_addr_a, wr_addr_b, layer, busy, done
    );

    modport slave (
        input  start, mode, en,
        output rd_en, rd_addr_a, rd_addr_b, tw_idx, sel,
        output wr_en, wr_addr_a, wr_addr_b, layer, busy, done
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// Kyber NTT/INTT address generator: walks 7 butterfly layers of a 256-coefficient polynomial,
// issuing one coefficient pair per cycle and echoing the addresses as write-back LAT cycles later.
module ntt_addr_gen #(
    parameter int RAM_LAT = 1,
    parameter int BF_LAT  = 3
) (
    input  logic          clk,
    input  logic          rst,
    ntt_addr_gen_if.slave bus
);
    localparam int LAT   = RAM_LAT + BF_LAT;
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int WB_W  = 17;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic             mode_reg, mode_next;
    logic [2:0]       l_reg, l_next;
    logic [6:0]       i_reg, i_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic       rd_en_reg, rd_en_next;
    logic [7:0] rd_addr_a_reg, rd_addr_a_next;
    logic [7:0] rd_addr_b_reg, rd_addr_b_next;
    logic [6:0] tw_idx_reg, tw_idx_next;
    logic [1:0] sel_reg, sel_next;
    logic [2:0] layer_reg;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;

    logic [2:0] sh;
    logic [7:0] i_ext, len, mask, pair_a, pair_b;
    logic [6:0] grp, tw_val;

    // Pair mapping: a is i with the group bits shifted up one place, b sits len above it.
    always_comb begin
        i_ext  = {1'b0, i_reg};
        sh     = mode_reg ? (l_reg + 3'd1) : (3'd7 - l_reg);
        len    = 8'd1 << sh;
        mask   = len - 8'd1;
        grp    = i_reg >> sh;
        pair_a = ((i_ext & ~mask) << 1) | (i_ext & mask);
        pair_b = pair_a + len;
        tw_val = mode_reg ? ((7'h7f >> l_reg) - grp) : ((7'd1 << l_reg) + grp);
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        l_next         = l_reg;
        i_next         = i_reg;
        cnt_next       = cnt_reg;
        rd_en_next     = 1'b0;
        rd_addr_a_next = rd_addr_a_reg;
        rd_addr_b_next = rd_addr_b_reg;
        tw_idx_next    = tw_idx_reg;
        sel_next       = 2'd2;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    mode_next  = bus.mode;
                    l_next     = 3'd0;
                    i_next     = 7'd0;
                    cnt_next   = '0;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                busy_next = 1'b1;
                sel_next  = {1'b0, mode_reg};
                if (bus.en) begin
                    rd_en_next     = 1'b1;
                    rd_addr_a_next = pair_a;
                    rd_addr_b_next = pair_b;
                    tw_idx_next    = tw_val;
                    i_next         = i_reg + 7'd1;
                    if (i_reg == 7'd127) begin
                        cnt_next   = '0;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Hold off the next layer until the last write-back of this one has landed.
                busy_next = 1'b1;
                sel_next  = {1'b0, mode_reg};
                if (cnt_reg == CNT_W'(LAT - 1)) begin
                    cnt_next = '0;
                    if (l_reg == 3'd6) begin
                        state_next = DONE;
                    end else begin
                        l_next     = l_reg + 3'd1;
                        i_next     = 7'd0;
                        state_next = ISSUE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            l_reg         <= 3'd0;
            i_reg         <= 7'd0;
            cnt_reg       <= '0;
            rd_en_reg     <= 1'b0;
            rd_addr_a_reg <= 8'd0;
            rd_addr_b_reg <= 8'd0;
            tw_idx_reg    <= 7'd0;
            sel_reg       <= 2'd2;
            layer_reg     <= 3'd0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            l_reg         <= l_next;
            i_reg         <= i_next;
            cnt_reg       <= cnt_next;
            rd_en_reg     <= rd_en_next;
            rd_addr_a_reg <= rd_addr_a_next;
            rd_addr_b_reg <= rd_addr_b_next;
            tw_idx_reg    <= tw_idx_next;
            sel_reg       <= sel_next;
            layer_reg     <= l_reg;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    // Write-back delay line shifts every cycle; the butterfly never stalls.
    for (genvar gi = 0; gi < LAT; gi++) begin : g_wb
        logic [WB_W-1:0] stage_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) stage_reg <= '0;
                else      stage_reg <= {rd_en_reg, rd_addr_a_reg, rd_addr_b_reg};
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) stage_reg <= '0;
                else      stage_reg <= g_wb[gi-1].stage_reg;
            end
        end
    end

    assign bus.rd_en     = rd_en_reg;
    assign bus.rd_addr_a = rd_addr_a_reg;
    assign bus.rd_addr_b = rd_addr_b_reg;
    assign bus.tw_idx    = tw_idx_reg;
    assign bus.sel       = sel_reg;
    assign bus.layer     = layer_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} = g_wb[LAT-1].stage_reg;
endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen: expected reads queued at start, matched on rd_en,
// then re-queued as expected write-backs LAT cycles later.
module tb_ntt_addr_gen;
    localparam int LAT = 4;

    typedef struct {
        int         cyc;
        logic [2:0] l;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] tw;
        logic [1:0] sel;
    } rd_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
    } wr_exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   wr_total = 0;
    int   wr_base = 0;
    int   t0 = 0;
    rd_exp_t rdq[$];
    wr_exp_t wrq[$];

    ntt_addr_gen_if bus ();

    ntt_addr_gen #(.RAM_LAT(1), .BF_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check_eq(tag, 64'({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.sel,
                           bus.wr_en, bus.wr_addr_a, bus.wr_addr_b, bus.layer, bus.busy, bus.done}),
                      64'({1'b0, 8'd0, 8'd0, 7'd0, 2'd2, 1'b0, 8'd0, 8'd0, 3'd0, 1'b0, 1'b0}));
    endtask

    // Reference pair mapping written straight from the len/grp/off definition.
    task automatic push_expected(input logic m, input int base, input int stall_n);
        rd_exp_t e;
        int len, grp, off, a, tw;
        for (int l = 0; l < 7; l++) begin
            for (int i = 0; i < 128; i++) begin
                len   = m ? (2 << l) : (128 >> l);
                grp   = i / len;
                off   = i % len;
                a     = 2 * len * grp + off;
                tw    = m ? ((128 >> l) - 1 - grp) : ((1 << l) + grp);
                e.cyc = base + l * (128 + LAT) + i + 1 + (((l > 2) || (l == 2 && i >= 40)) ? stall_n : 0);
                e.l   = 3'(l);
                e.a   = 8'(a);
                e.b   = 8'(a + len);
                e.tw  = 7'(tw);
                e.sel = {1'b0, m};
                rdq.push_back(e);
            end
        end
    endtask

    // Advance to the next falling edge and score whatever the DUT produced.
    task automatic tick();
        rd_exp_t e;
        wr_exp_t w;
        @(negedge clk);
        if (bus.rd_en === 1'b1) begin
            if (rdq.size() == 0) begin
                check_eq("rd_unexpected", 64'(bus.rd_en), 64'(0));
            end else begin
                e = rdq.pop_front();
                check_eq("rd_fields", 64'({bus.layer, bus.rd_addr_a, bus.rd_addr_b, bus.tw_idx, bus.sel}),
                                      64'({e.l, e.a, e.b, e.tw, e.sel}));
                check_eq("rd_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("rd_after_wb", 64'((wr_total - wr_base) >= 128 * int'(bus.layer)), 64'(1));
                w.cyc = e.cyc + LAT;
                w.a   = e.a;
                w.b   = e.b;
                wrq.push_back(w);
            end
        end
        if (bus.wr_en === 1'b1) begin
            wr_total++;
            if (wrq.size() == 0) begin
                check_eq("wr_unexpected", 64'(bus.wr_en), 64'(0));
            end else begin
                w = wrq.pop_front();
                check_eq("wr_addr", 64'({bus.wr_addr_a, bus.wr_addr_b}), 64'({w.a, w.b}));
                check_eq("wr_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
    endtask

    task automatic do_abort();
        #1 rst = 1'b0;
        #1 check_idle_outs("async_rst_outs");
        rdq.delete();
        wrq.delete();
        for (int k = 0; k < 6; k++) begin
            tick();
            check_eq("rst_no_wr", 64'({bus.wr_en, bus.rd_en}), 64'(0));
        end
        rst = 1'b1;
        tick();
        check_idle_outs("abort_release_outs");
    endtask

    task automatic run_xform(input logic m, input int stall_n, input bit repulse,
                             input int abort_at, input string name);
        int rel;
        int done_at;
        bus.mode  = m;
        bus.start = 1'b1;
        t0        = cyc + 1;
        wr_base   = wr_total;
        push_expected(m, t0, stall_n);
        tick();
        bus.start = 1'b0;
        check_eq("busy_at_start", 64'(bus.busy), 64'(0));
        done_at = -1;
        for (int k = 0; k < 1100 && done_at < 0; k++) begin
            rel = cyc - t0;
            if (abort_at > 0 && rel == abort_at) begin
                do_abort();
                $display("xform %s mode=%0d aborted_at=%0d wr=%0d", name, m, rel, wr_total - wr_base);
                return;
            end
            if (stall_n > 0 && rel == 304) bus.en = 1'b0;
            if (stall_n > 0 && rel == 304 + stall_n) bus.en = 1'b1;
            if (repulse) bus.start = (rel == 299);
            tick();
            rel = cyc - t0;
            if (rel == 1) check_eq("busy_on", 64'(bus.busy), 64'(1));
            if (stall_n > 0 && rel >= 305 && rel < 305 + stall_n)
                check_eq("stall_hold", 64'({bus.rd_en, bus.rd_addr_a, bus.rd_addr_b}),
                                       64'({1'b0, 8'd71, 8'd103}));
            if (bus.done === 1'b1) begin
                done_at = rel;
                check_eq("busy_at_done", 64'(bus.busy), 64'(0));
            end
        end
        bus.start = 1'b0;
        check_eq("done_cycle", 64'(done_at), 64'(925 + stall_n));
        tick();
        check_eq("after_done", 64'({bus.done, bus.busy, bus.sel}), 64'({1'b0, 1'b0, 2'd2}));
        check_eq("wr_count", 64'(wr_total - wr_base), 64'(896));
        check_eq("queues_empty", 64'(rdq.size() + wrq.size()), 64'(0));
        $display("xform %s mode=%0d done_at=%0d wr=%0d", name, m, done_at, wr_total - wr_base);
    endtask

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.en    = 1'b1;
        repeat (3) tick();
        check_idle_outs("reset_outs");
        rst = 1'b1;
        tick();
        check_idle_outs("release_outs");
        run_xform(1'b0, 0, 1'b0, 0,   "ntt");
        run_xform(1'b1, 0, 1'b1, 0,   "intt_restart_ignored");
        run_xform(1'b0, 5, 1'b0, 0,   "ntt_stall");
        run_xform(1'b1, 0, 1'b0, 500, "intt_abort");
        run_xform(1'b0, 0, 1'b0, 0,   "ntt_after_abort");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
